// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ byte producers.
// Latency: byte accepted in LOAD, tx_start on the next enabled cycle; one byte in flight.
// Backpressure: req_ready only while loading; the next byte waits for the tx_busy window to close.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 2170
) (
    input  logic                   txclk,
    input  logic                   rst_n,
    input  logic                   txclken,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   grant_valid,
    output logic [2:0]             grant_id,
    output logic                   err_timeout
);

    localparam int TW = $clog2(START_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      tx_data_nxt;
    logic            tx_start_nxt, grant_valid_nxt, err_timeout_nxt;
    logic [2:0]      grant_id_nxt, last_grant, last_grant_nxt;
    logic [7:0]      burst_cnt, burst_cnt_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            last_q, last_q_nxt;

    logic            any_vld, hi_vld, win_vld;
    logic [2:0]      any_id, hi_id, win_id;
    logic            sel_vld, sel_last;
    logic [7:0]      sel_dat;

    // Round robin: lowest valid index above last_grant, else wrap to lowest valid index.
    always_comb begin
        any_vld = 1'b0;
        any_id  = '0;
        hi_vld  = 1'b0;
        hi_id   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_vld = 1'b1;
                any_id  = 3'(i);
            end
            if (req_valid[i] && (3'(i) > last_grant)) begin
                hi_vld = 1'b1;
                hi_id  = 3'(i);
            end
        end
        win_vld = any_vld;
        win_id  = hi_vld ? hi_id : any_id;
    end

    always_comb begin
        sel_vld   = 1'b0;
        sel_last  = 1'b0;
        sel_dat   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_vld      = req_valid[i];
                sel_last     = req_last[i];
                sel_dat      = req_data[8*i +: 8];
                req_ready[i] = (state == LOAD) && txclken;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        tx_data_nxt     = tx_data;
        tx_start_nxt    = 1'b0;
        grant_valid_nxt = grant_valid;
        grant_id_nxt    = grant_id;
        err_timeout_nxt = 1'b0;
        last_grant_nxt  = last_grant;
        burst_cnt_nxt   = burst_cnt;
        timer_nxt       = timer;
        last_q_nxt      = last_q;
        case (state)
            IDLE: begin
                if (|req_valid && !tx_busy) state_nxt = ARB;
            end
            ARB: begin
                if (win_vld) begin
                    grant_id_nxt    = win_id;
                    grant_valid_nxt = 1'b1;
                    last_grant_nxt  = win_id;
                    burst_cnt_nxt   = '0;
                    state_nxt       = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (sel_vld) begin
                    tx_data_nxt   = sel_dat;
                    last_q_nxt    = sel_last;
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    tx_start_nxt  = 1'b1;
                    state_nxt     = START;
                end else begin
                    grant_valid_nxt = 1'b0;
                    state_nxt       = ARB;
                end
            end
            START: begin
                timer_nxt = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == TW'(START_TIMEOUT - 2)) begin
                    // timer reaches START_TIMEOUT-1 on this edge; the byte is abandoned
                    timer_nxt       = timer + TW'(1);
                    err_timeout_nxt = 1'b1;
                    grant_valid_nxt = 1'b0;
                    state_nxt       = ARB;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || (burst_cnt == 8'(MAX_BURST))) begin
                        grant_valid_nxt = 1'b0;
                        state_nxt       = ARB;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            last_grant  <= 3'(NUM_REQ - 1);
            burst_cnt   <= '0;
            timer       <= '0;
            last_q      <= 1'b0;
        end else if (txclken) begin
            state       <= state_nxt;
            tx_data     <= tx_data_nxt;
            tx_start    <= tx_start_nxt;
            grant_valid <= grant_valid_nxt;
            grant_id    <= grant_id_nxt;
            err_timeout <= err_timeout_nxt;
            last_grant  <= last_grant_nxt;
            burst_cnt   <= burst_cnt_nxt;
            timer       <= timer_nxt;
            last_q      <= last_q_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer queues, a transmitter busy model and
// a start/err monitor, all advanced once per clock from the single stimulus process.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 2170;

    logic            txclk;
    logic            rst_n;
    logic            txclken;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            grant_valid;
    logic [2:0]      grant_id;
    logic            err_timeout;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16), .START_TIMEOUT(TO)) dut (
        .txclk(txclk), .rst_n(rst_n), .txclken(txclken),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
        .err_timeout(err_timeout)
    );

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ecyc  = 0;
    int div   = 1;
    int dly   = 0;
    int bcnt  = 0;
    bit no_busy = 1'b0;

    logic [8:0] q [NR][$];
    logic [2:0] log_gid [$];
    logic [7:0] log_dat [$];
    int         log_e   [$];

    int   ready_viol, width_viol, err_cnt, err_e, gv_falls;
    logic err_gv, prev_st, prev_gv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        q[i].push_back({last, d});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (q[i].size() > 0);
            req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
            req_last[i]        = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
        end
        txclken = ((cyc % div) == 0);
        tx_busy = (bcnt > 0) && !no_busy;
    endtask

    // One clock: sample this cycle's values, cross the rising edge, then update models.
    task automatic step();
        logic [NR-1:0] fire;
        logic en, st;
        #1;
        fire = req_valid & req_ready;
        en   = txclken;
        st   = tx_start;
        if (!txclken && (|req_ready)) ready_viol++;
        if (en && st) begin
            if (prev_st) width_viol++;
            log_gid.push_back(grant_id);
            log_dat.push_back(tx_data);
            log_e.push_back(ecyc);
        end
        if (en) prev_st = st;
        if (en && err_timeout) begin
            err_cnt++;
            err_e  = ecyc;
            err_gv = grant_valid;
        end
        if (prev_gv && !grant_valid) gv_falls++;
        prev_gv = grant_valid;
        if (en) ecyc++;
        @(negedge txclk);
        cyc++;
        if (rst_n) begin
            for (int i = 0; i < NR; i++)
                if (fire[i]) void'(q[i].pop_front());
            if (en) begin
                if (st) dly = 2;
                else if (dly > 0) begin
                    dly--;
                    if (dly == 0) bcnt = 10;
                end else if (bcnt > 0) bcnt--;
            end
        end
        drive();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NR; i++)
            if (q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_logs();
        log_gid.delete();
        log_dat.delete();
        log_e.delete();
        ready_viol = 0;
        width_viol = 0;
        err_cnt    = 0;
        err_e      = 0;
        err_gv     = 1'b1;
        gv_falls   = 0;
    endtask

    task automatic run_until_quiet(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            step();
            n++;
            if (all_empty() && !grant_valid && !tx_busy && dly == 0) quiet++;
            else quiet = 0;
        end
        check({tag, "_quiet"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic wait_for_grant(input string tag, input logic [2:0] id, input int budget);
        int n = 0;
        while (!(grant_valid && grant_id == id) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(grant_valid && grant_id == id), 32'd1);
    endtask

    task automatic expect_log(input string tag, input int i, input logic [2:0] g, input logic [7:0] d);
        if (i < log_dat.size()) begin
            check({tag, "_gid"}, 32'(log_gid[i]), 32'(g));
            check({tag, "_dat"}, 32'(log_dat[i]), 32'(d));
        end else begin
            check({tag, "_missing"}, log_dat.size(), i + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) q[i].delete();
        dly  = 0;
        bcnt = 0;
        drive();
        repeat (2) @(negedge txclk);
        rst_n   = 1'b1;
        prev_gv = 1'b0;
        prev_st = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b1;
        txclken   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        prev_st   = 1'b0;
        prev_gv   = 1'b0;
        clear_logs();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge txclk);
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge txclk);
        rst_n = 1'b1;
        drive();

        // single requester, two bytes in one burst
        clear_logs();
        push(0, 1'b0, 8'h55);
        push(0, 1'b1, 8'hA3);
        drive();
        run_until_quiet("s1", 400);
        check("s1_count", log_dat.size(), 2);
        expect_log("s1_b0", 0, 3'd0, 8'h55);
        expect_log("s1_b1", 1, 3'd0, 8'hA3);
        check("s1_gv_falls", gv_falls, 1);
        check("s1_start_width", width_viol, 0);

        // two continuously valid requesters alternate
        do_reset();
        clear_logs();
        push(1, 1'b1, 8'h11);
        push(1, 1'b1, 8'h12);
        push(3, 1'b1, 8'h31);
        push(3, 1'b1, 8'h32);
        drive();
        run_until_quiet("s2", 600);
        check("s2_count", log_dat.size(), 4);
        expect_log("s2_b0", 0, 3'd1, 8'h11);
        expect_log("s2_b1", 1, 3'd3, 8'h31);
        expect_log("s2_b2", 2, 3'd1, 8'h12);
        expect_log("s2_b3", 3, 3'd3, 8'h32);

        // long stream is cut at 16 bytes so the pending requester gets a turn
        clear_logs();
        for (int k = 0; k < 20; k++) push(2, 1'b0, 8'(8'h80 + k));
        drive();
        wait_for_grant("s3_grant2", 3'd2, 20);
        push(0, 1'b1, 8'hC0);
        drive();
        run_until_quiet("s3", 1500);
        check("s3_count", log_dat.size(), 21);
        for (int k = 0; k < 16; k++) expect_log("s3_first", k, 3'd2, 8'(8'h80 + k));
        expect_log("s3_req0", 16, 3'd0, 8'hC0);
        for (int k = 16; k < 20; k++) expect_log("s3_resume", k + 1, 3'd2, 8'(8'h80 + k));

        // transmitter never goes busy
        clear_logs();
        no_busy = 1'b1;
        push(3, 1'b1, 8'hD3);
        push(0, 1'b1, 8'hD0);
        drive();
        n = 0;
        while (err_cnt == 0 && n < TO + 200) begin
            step();
            n++;
        end
        check("s4_err_seen", 32'(err_cnt), 32'd1);
        no_busy = 1'b0;
        run_until_quiet("s4", 400);
        check("s4_err_count", err_cnt, 1);
        check("s4_gv_at_err", 32'(err_gv), 32'd0);
        if (log_e.size() > 0) check("s4_err_delay", err_e - log_e[0], TO);
        else check("s4_no_start", log_e.size(), 1);
        check("s4_count", log_dat.size(), 2);
        expect_log("s4_b0", 0, 3'd3, 8'hD3);
        expect_log("s4_b1", 1, 3'd0, 8'hD0);

        // clock enable 1-in-8
        clear_logs();
        div = 8;
        push(0, 1'b0, 8'h55);
        push(0, 1'b1, 8'hA3);
        drive();
        run_until_quiet("s5", 4000);
        check("s5_count", log_dat.size(), 2);
        expect_log("s5_b0", 0, 3'd0, 8'h55);
        expect_log("s5_b1", 1, 3'd0, 8'hA3);
        check("s5_start_width", width_viol, 0);
        check("s5_ready_gated", ready_viol, 0);
        check("s5_gv_falls", gv_falls, 1);
        div = 1;
        drive();

        // reset while a frame is in progress for requester 2
        clear_logs();
        push(2, 1'b1, 8'hB2);
        drive();
        wait_for_grant("s6_grant2", 3'd2, 20);
        n = 0;
        while (!tx_busy && n < 50) begin
            step();
            n++;
        end
        check("s6_busy_seen", 32'(tx_busy), 32'd1);
        step();
        step();
        check("s6_pre_gid", 32'(grant_id), 32'd2);
        check("s6_pre_gv", 32'(grant_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_tx_start", 32'(tx_start), 32'd0);
        check("s6_rst_tx_data", 32'(tx_data), 32'h00);
        check("s6_rst_gv", 32'(grant_valid), 32'd0);
        check("s6_rst_gid", 32'(grant_id), 32'd0);
        check("s6_rst_err", 32'(err_timeout), 32'd0);
        check("s6_rst_ready", 32'(req_ready), 32'd0);
        do_reset();
        clear_logs();
        push(1, 1'b1, 8'h71);
        push(2, 1'b1, 8'h72);
        push(3, 1'b1, 8'h73);
        drive();
        run_until_quiet("s6", 600);
        check("s6_count", log_dat.size(), 3);
        expect_log("s6_b0", 0, 3'd1, 8'h71);
        expect_log("s6_b1", 1, 3'd2, 8'h72);
        expect_log("s6_b2", 2, 3'd3, 8'h73);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
